vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock enable, h/v counters,
// registered sync/de/coordinates, snake-grid cell coordinates and event pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int CLK_DIV   = 4,
  parameter int CELL_SIZE = 10,
  parameter int CW        = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic          pix_ce,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [CW-1:0] cell_x,
  output logic [CW-1:0] cell_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] D_LAST       = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT        = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT        = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] CELL_LAST    = CW'(CELL_SIZE - 1);
  localparam logic          HS_ACT       = (HS_POL != 0);
  localparam logic          VS_ACT       = (VS_POL != 0);

  function automatic logic in_window(input logic [CW-1:0] pos,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  logic [DW-1:0] d_cnt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] x_off;
  logic [CW-1:0] y_off;
  logic [CW-1:0] cx_cnt;
  logic [CW-1:0] cy_cnt;

  logic          tick;
  logic          line_wrap;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic [CW-1:0] x_off_nxt;
  logic [CW-1:0] y_off_nxt;
  logic [CW-1:0] cx_nxt;
  logic [CW-1:0] cy_nxt;
  logic          de_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          at_line0;

  assign tick = run && (d_cnt == D_LAST);

  // Candidate raster position for the next tick; only committed when tick is high.
  always_comb begin
    h_nxt     = h_cnt + 1'b1;
    v_nxt     = v_cnt;
    line_wrap = 1'b0;
    if (h_cnt == H_LAST) begin
      h_nxt     = '0;
      line_wrap = 1'b1;
      v_nxt     = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
  end

  // Cell coordinates advance with a sub-cell offset instead of dividing x and y.
  always_comb begin
    x_off_nxt = x_off;
    cx_nxt    = cx_cnt;
    if (h_nxt == '0) begin
      x_off_nxt = '0;
      cx_nxt    = '0;
    end else if (h_nxt < H_ACT) begin
      if (x_off == CELL_LAST) begin
        x_off_nxt = '0;
        cx_nxt    = cx_cnt + 1'b1;
      end else begin
        x_off_nxt = x_off + 1'b1;
      end
    end
  end

  always_comb begin
    y_off_nxt = y_off;
    cy_nxt    = cy_cnt;
    if (line_wrap) begin
      if (v_nxt == '0) begin
        y_off_nxt = '0;
        cy_nxt    = '0;
      end else if (v_nxt < V_ACT) begin
        if (y_off == CELL_LAST) begin
          y_off_nxt = '0;
          cy_nxt    = cy_cnt + 1'b1;
        end else begin
          y_off_nxt = y_off + 1'b1;
        end
      end
    end
  end

  always_comb begin
    de_nxt   = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_nxt   = in_window(h_nxt, H_SYNC_START, H_SYNC_END) ? HS_ACT : !HS_ACT;
    vs_nxt   = in_window(v_nxt, V_SYNC_START, V_SYNC_END) ? VS_ACT : !VS_ACT;
    at_line0 = (h_nxt == '0);
  end

  // Divider and raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_cnt  <= '0;
      h_cnt  <= H_LAST;
      v_cnt  <= V_LAST;
      x_off  <= '0;
      y_off  <= '0;
      cx_cnt <= '0;
      cy_cnt <= '0;
    end else begin
      if (run) begin
        d_cnt <= tick ? '0 : d_cnt + 1'b1;
      end
      if (tick) begin
        h_cnt  <= h_nxt;
        v_cnt  <= v_nxt;
        x_off  <= x_off_nxt;
        y_off  <= y_off_nxt;
        cx_cnt <= cx_nxt;
        cy_cnt <= cy_nxt;
      end
    end
  end

  // Output register: decoded from next-state counters so it lines up with pix_ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_ce       <= 1'b0;
      de           <= 1'b0;
      h_sync       <= !HS_ACT;
      v_sync       <= !VS_ACT;
      x            <= '0;
      y            <= '0;
      cell_x       <= '0;
      cell_y       <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      pix_ce       <= tick;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      if (tick) begin
        de           <= de_nxt;
        h_sync       <= hs_nxt;
        v_sync       <= vs_nxt;
        x            <= de_nxt ? h_nxt  : '0;
        y            <= de_nxt ? v_nxt  : '0;
        cell_x       <= de_nxt ? cx_nxt : '0;
        cell_y       <= de_nxt ? cy_nxt : '0;
        line_start   <= at_line0;
        frame_start  <= at_line0 && (v_nxt == '0);
        vblank_start <= at_line0 && (v_nxt == V_ACT);
      end
    end
  end

endmodule
